gty_reset_sequencer: RTL

// Per-lane GTY bring-up sequencer. Sits between the shared QPLL (qpll_lock) and one GTY lane bridge.
// - Holds the TX and RX datapath resets until the selected QPLL has been locked for a settle interval.
// - Releases TX, then RX, then reports link_up.
// - Retries on resetdone timeout and re-sequences on QPLL lock loss, CDR loss or a restart request.
//

---
 rtl/gty_pkg.sv | 21 ++
 rtl/bit_sync2.sv | 26 ++
 rtl/gty_reset_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gty_pkg.sv
// Shared types and constants for the GTY lane reset sequencer.
package gty_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    TX_RESET  = 3'd1,
    TX_WAIT   = 3'd2,
    RX_RESET  = 3'd3,
    RX_WAIT   = 3'd4,
    READY     = 3'd5
  } gty_rst_state_t;

  localparam int GTY_SYNC_STAGES = 2;

  function automatic int gty_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Multi-stage flop synchronizer for independent asynchronous bits; GTY_SYNC_STAGES cycles of latency.
// Bits are not related to each other, so no coherency between them is implied.
module bit_sync2
  import gty_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [GTY_SYNC_STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[GTY_SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[GTY_SYNC_STAGES-1];

endmodule

// File: rtl/gty_reset_sequencer.sv
// Per-lane GTY bring-up: waits for a settled QPLL lock, pulses TX then RX datapath resets, reports link_up.
// All outputs are registered and track the FSM state; aborts to WAIT_LOCK on lock loss or restart.
module gty_reset_sequencer
  import gty_pkg::*;
#(
  parameter int QPLL_SEL            = 1,
  parameter int LOCK_SETTLE_CYCLES  = 1024,
  parameter int RESET_PULSE_CYCLES  = 64,
  parameter int DONE_TIMEOUT_CYCLES = 65536
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [1:0] qpll_lock,
  input  logic       tx_resetdone,
  input  logic       rx_resetdone,
  input  logic       rx_cdr_lock,
  input  logic       restart,
  output logic       tx_reset,
  output logic       rx_reset,
  output logic       tx_userrdy,
  output logic       rx_userrdy,
  output logic       link_up,
  output logic [2:0] state_out,
  output logic [7:0] retry_count
);

  localparam int CNT_MAX = gty_max3(LOCK_SETTLE_CYCLES, RESET_PULSE_CYCLES, DONE_TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT_CYCLES - 1);

  logic [1:0] qpll_lock_s;
  logic       tx_done_s;
  logic       rx_done_s;
  logic       cdr_s;
  logic       lock_ok;
  logic       qpll_sync_unused;

  bit_sync2 #(.WIDTH(2)) u_sync_qpll   (.clk(sysclk), .rst(rst), .d(qpll_lock),    .q(qpll_lock_s));
  bit_sync2 #(.WIDTH(1)) u_sync_txdone (.clk(sysclk), .rst(rst), .d(tx_resetdone), .q(tx_done_s));
  bit_sync2 #(.WIDTH(1)) u_sync_rxdone (.clk(sysclk), .rst(rst), .d(rx_resetdone), .q(rx_done_s));
  bit_sync2 #(.WIDTH(1)) u_sync_cdr    (.clk(sysclk), .rst(rst), .d(rx_cdr_lock),  .q(cdr_s));

  // Both QPLL bits are synchronized so either can be selected; only one gates this lane.
  assign lock_ok          = qpll_lock_s[QPLL_SEL];
  assign qpll_sync_unused = ^qpll_lock_s;

  gty_rst_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             retry_bump;

  logic tx_reset_q, tx_reset_d;
  logic rx_reset_q, rx_reset_d;
  logic tx_userrdy_q, tx_userrdy_d;
  logic rx_userrdy_q, rx_userrdy_d;
  logic link_up_q, link_up_d;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      retry_q      <= '0;
      tx_reset_q   <= 1'b1;
      rx_reset_q   <= 1'b1;
      tx_userrdy_q <= 1'b0;
      rx_userrdy_q <= 1'b0;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      tx_reset_q   <= tx_reset_d;
      rx_reset_q   <= rx_reset_d;
      tx_userrdy_q <= tx_userrdy_d;
      rx_userrdy_q <= rx_userrdy_d;
      link_up_q    <= link_up_d;
    end
  end

  // Abort beats timeout, and a resetdone beats a timeout landing on the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    retry_d    = retry_q;
    retry_bump = 1'b0;
    if (state_q != WAIT_LOCK && (!lock_ok || restart)) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!lock_ok || restart) begin
            cnt_d = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = TX_RESET;
          end
        end
        TX_RESET: begin
          if (cnt_q == PULSE_LAST) state_d = TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done_s) begin
            state_d = RX_RESET;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d    = TX_RESET;
            retry_bump = 1'b1;
          end
        end
        RX_RESET: begin
          if (cnt_q == PULSE_LAST) state_d = RX_WAIT;
        end
        RX_WAIT: begin
          if (rx_done_s && cdr_s) begin
            state_d = READY;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d    = RX_RESET;
            retry_bump = 1'b1;
          end
        end
        READY: begin
          cnt_d = '0;
          if (!cdr_s) state_d = RX_RESET;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
    if (retry_bump && retry_q != 8'hFF) retry_d = retry_q + 8'd1;
  end

  // Outputs are decoded from the next state so each registered output lines up with state_q.
  always_comb begin
    tx_reset_d   = 1'b1;
    rx_reset_d   = 1'b1;
    tx_userrdy_d = 1'b0;
    rx_userrdy_d = 1'b0;
    link_up_d    = 1'b0;
    case (state_d)
      TX_WAIT, RX_RESET: begin
        tx_reset_d   = 1'b0;
        tx_userrdy_d = 1'b1;
      end
      RX_WAIT: begin
        tx_reset_d   = 1'b0;
        tx_userrdy_d = 1'b1;
        rx_reset_d   = 1'b0;
        rx_userrdy_d = 1'b1;
      end
      READY: begin
        tx_reset_d   = 1'b0;
        tx_userrdy_d = 1'b1;
        rx_reset_d   = 1'b0;
        rx_userrdy_d = 1'b1;
        link_up_d    = 1'b1;
      end
      default: begin
        tx_reset_d = 1'b1;
      end
    endcase
  end

  assign tx_reset    = tx_reset_q;
  assign rx_reset    = rx_reset_q;
  assign tx_userrdy  = tx_userrdy_q;
  assign rx_userrdy  = rx_userrdy_q;
  assign link_up     = link_up_q;
  assign state_out   = state_q;
  assign retry_count = retry_q;

endmodule
